// File: rtl/temperature_pkg.sv
// temperature_pkg
// Shared definitions for the temperature monitor: FSM state encoding,
// display (LED) codes, comfort band limits and the LED classification helper.
package temperature_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DIVIDE,
    ST_ROUND,
    ST_DONE
  } state_t;

  localparam logic [7:0] LED_NONE = 8'h00;
  localparam logic [7:0] LED_COLD = 8'h01;
  localparam logic [7:0] LED_OK   = 8'h02;
  localparam logic [7:0] LED_HOT  = 8'h04;

  // Comfort band: BAND_LO..BAND_HI inclusive shows LED_OK.
  localparam logic [7:0] BAND_LO = 8'd19;
  localparam logic [7:0] BAND_HI = 8'd26;

  function automatic logic [7:0] led_code(input logic [7:0] avg,
                                          input logic [7:0] count);
    if (count == 8'd0)     return LED_NONE;
    else if (avg < BAND_LO) return LED_COLD;
    else if (avg <= BAND_HI) return LED_OK;
    else                    return LED_HOT;
  endfunction

endpackage

// File: rtl/temperature_monitor_divider.sv
// seq_divider
// 16-bit restoring divider, one quotient bit per clock.
// The start edge loads the operands and already resolves the first quotient
// bit, so 16 edges (start edge included) produce the result; done_o pulses
// for one cycle right after the last bit, with quotient/remainder registered.
// Ports:
//   clk_i, rst_n_i        clock, async active-low reset
//   start_i               load operands and begin
//   dividend_i, divisor_i 16-bit operands
//   done_o                one-cycle pulse, result valid
//   quotient_o, remainder_o  registered result
module seq_divider (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [15:0] dividend_i,
  input  logic [15:0] divisor_i,
  output logic        done_o,
  output logic [15:0] quotient_o,
  output logic [15:0] remainder_o
);

  logic [15:0] rem_q;
  logic [15:0] quo_q;
  logic [15:0] dvs_q;
  logic [3:0]  cnt_q;
  logic        active_q;

  // One restoring step: shift in next dividend bit, subtract when it fits.
  // Since rem < dvs, trial - dvs always fits in 16 bits.
  function automatic logic [31:0] div_step(input logic [15:0] rem,
                                           input logic [15:0] quo,
                                           input logic [15:0] dvs);
    logic [16:0] trial;
    logic [15:0] diff;
    trial = {rem, quo[15]};
    diff  = trial[15:0] - dvs;
    if (trial >= {1'b0, dvs}) return {diff, quo[14:0], 1'b1};
    else                      return {trial[15:0], quo[14:0], 1'b0};
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        {rem_q, quo_q} <= div_step('0, dividend_i, divisor_i);
        dvs_q          <= divisor_i;
        cnt_q          <= 4'd15;
        active_q       <= 1'b1;
      end else if (active_q) begin
        {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
        cnt_q          <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          active_q <= 1'b0;
          done_o   <= 1'b1;
        end
      end
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/temperature_monitor.sv
// temperature_monitor
// Latches a snapshot of NR_SENSORS 8-bit temperatures on start, sums the
// enabled ones (one per cycle), divides by the enabled count, rounds to
// nearest, and publishes average, count, LED code and a hysteretic alert.
// Fixed latency: results and done_o appear NR_SENSORS+17 edges after start.
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   start_i          measurement request (sampled in IDLE only)
//   sensors_data_i   8 bits per sensor, sensor k at [8k+7:8k]
//   sensors_en_i     per-sensor enables
//   busy_o, done_o   status; done_o is a one-cycle result pulse
//   avg_o, nr_active_o, led_output_o, alert_o  results, held between runs
module temperature_monitor
  import temperature_pkg::*;
#(
  parameter int NR_SENSORS = 5,
  parameter int ALERT_HI   = 40,
  parameter int ALERT_LO   = 35
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic [8*NR_SENSORS-1:0] sensors_data_i,
  input  logic [NR_SENSORS-1:0]   sensors_en_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [7:0]              avg_o,
  output logic [7:0]              nr_active_o,
  output logic [7:0]              led_output_o,
  output logic                    alert_o
);

  localparam logic [4:0] LAST_IDX = 5'(NR_SENSORS - 1);
  localparam logic [7:0] HI_LIM   = 8'(ALERT_HI);
  localparam logic [7:0] LO_LIM   = 8'(ALERT_LO);

  state_t                  state_q;
  logic [8*NR_SENSORS-1:0] data_q;
  logic [NR_SENSORS-1:0]   en_q;
  logic [15:0]             sum_q;
  logic [7:0]              count_q;
  logic [4:0]              idx_q;

  logic        div_start;
  logic        div_done;
  logic [15:0] div_q;
  logic [15:0] div_r;

  logic [16:0] rounded;
  logic [7:0]  avg_next;
  logic        alert_next;

  // Sum is final once ACCUM ends, so the divider is kicked on the first
  // DIVIDE cycle; it then spans exactly the 16 DIVIDE cycles.
  assign div_start = (state_q == ST_DIVIDE) && (idx_q == 5'd0);

  seq_divider u_divider (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (div_start),
    .dividend_i  (sum_q),
    .divisor_i   ({8'b0, count_q}),
    .done_o      (div_done),
    .quotient_o  (div_q),
    .remainder_o (div_r)
  );

  always_comb begin
    rounded = {1'b0, div_q};
    if ({div_r, 1'b0} >= {9'b0, count_q}) rounded = {1'b0, div_q} + 17'd1;

    if (count_q == 8'd0)         avg_next = 8'd0;
    else if (rounded > 17'd255)  avg_next = 8'hFF;
    else                         avg_next = rounded[7:0];

    alert_next = alert_o;
    if (count_q == 8'd0 || avg_next >= HI_LIM) alert_next = 1'b1;
    else if (avg_next <= LO_LIM)               alert_next = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      en_q         <= '0;
      sum_q        <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      avg_o        <= '0;
      nr_active_o  <= '0;
      led_output_o <= '0;
      alert_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            data_q  <= sensors_data_i;
            en_q    <= sensors_en_i;
            sum_q   <= '0;
            count_q <= '0;
            idx_q   <= '0;
            busy_o  <= 1'b1;
            state_q <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          // Snapshot is shifted down so the current sensor is always at LSB.
          if (en_q[0]) begin
            sum_q   <= sum_q + {8'b0, data_q[7:0]};
            count_q <= count_q + 8'd1;
          end
          data_q <= data_q >> 8;
          en_q   <= en_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= ST_DIVIDE;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        ST_DIVIDE: begin
          if (idx_q == 5'd15) begin
            idx_q   <= '0;
            state_q <= ST_ROUND;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        ST_ROUND: begin
          if (div_done) begin
            avg_o        <= avg_next;
            nr_active_o  <= count_q;
            led_output_o <= led_code(avg_next, count_q);
            alert_o      <= alert_next;
            done_o       <= 1'b1;
            busy_o       <= 1'b0;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temperature_monitor.sv
// tb_temperature_monitor
// Directed bench for temperature_monitor (5 sensors, alert 40/35) with
// hand-computed expected values.
module tb_temperature_monitor;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic [39:0] sensors_data_i;
  logic [4:0]  sensors_en_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  avg_o;
  logic [7:0]  nr_active_o;
  logic [7:0]  led_output_o;
  logic        alert_o;

  int errors = 0;
  int checks = 0;

  temperature_monitor #(
    .NR_SENSORS (5),
    .ALERT_HI   (40),
    .ALERT_LO   (35)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .start_i        (start_i),
    .sensors_data_i (sensors_data_i),
    .sensors_en_i   (sensors_en_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .avg_o          (avg_o),
    .nr_active_o    (nr_active_o),
    .led_output_o   (led_output_o),
    .alert_o        (alert_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] pack5(input logic [7:0] s0, input logic [7:0] s1,
                                        input logic [7:0] s2, input logic [7:0] s3,
                                        input logic [7:0] s4);
    return {s4, s3, s2, s1, s0};
  endfunction

  function automatic logic [39:0] all5(input logic [7:0] v);
    return pack5(v, v, v, v, v);
  endfunction

  // One full measurement: start at edge 0, expect done_o after edge 22.
  task automatic run_check(input string tag, input logic [39:0] data,
                           input logic [4:0] en, input logic [7:0] e_avg,
                           input logic [7:0] e_cnt, input logic [7:0] e_led,
                           input logic e_alert);
    int edge_n;
    logic seen;
    @(negedge clk_i);
    start_i        = 1'b1;
    sensors_data_i = data;
    sensors_en_i   = en;
    @(posedge clk_i);
    #1;
    check_eq({tag, ".busy_start"}, 32'(busy_o), 32'd1);
    start_i = 1'b0;
    edge_n  = 0;
    seen    = 1'b0;
    while (!seen && edge_n < 40) begin
      @(posedge clk_i);
      edge_n++;
      #1;
      if (done_o) seen = 1'b1;
      else if (edge_n == 21) check_eq({tag, ".busy_e21"}, 32'(busy_o), 32'd1);
    end
    check_eq({tag, ".latency"}, 32'(edge_n), 32'd22);
    check_eq({tag, ".avg"},     32'(avg_o), 32'(e_avg));
    check_eq({tag, ".cnt"},     32'(nr_active_o), 32'(e_cnt));
    check_eq({tag, ".led"},     32'(led_output_o), 32'(e_led));
    check_eq({tag, ".alert"},   32'(alert_o), 32'(e_alert));
    check_eq({tag, ".busy_done"}, 32'(busy_o), 32'd0);
    @(posedge clk_i);
    #1;
    check_eq({tag, ".done_pulse"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    int ndone;
    int first_e;
    int second_e;

    rst_n_i        = 1'b0;
    start_i        = 1'b0;
    sensors_data_i = '0;
    sensors_en_i   = '0;
    #12;
    check_eq("rst.busy",  32'(busy_o), 32'd0);
    check_eq("rst.done",  32'(done_o), 32'd0);
    check_eq("rst.avg",   32'(avg_o), 32'd0);
    check_eq("rst.cnt",   32'(nr_active_o), 32'd0);
    check_eq("rst.led",   32'(led_output_o), 32'd0);
    check_eq("rst.alert", 32'(alert_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    run_check("avg22",   pack5(20, 21, 22, 23, 24), 5'h1F, 8'd22, 8'd5, 8'h02, 1'b0);
    run_check("pair",    pack5(10, 11, 200, 200, 200), 5'h03, 8'd11, 8'd2, 8'h01, 1'b0);
    run_check("none",    all5(8'd50), 5'h00, 8'd0, 8'd0, 8'h00, 1'b1);
    run_check("hys42",   all5(8'd42), 5'h1F, 8'd42, 8'd5, 8'h04, 1'b1);
    run_check("hys37a",  all5(8'd37), 5'h1F, 8'd37, 8'd5, 8'h04, 1'b1);
    run_check("hys35",   all5(8'd35), 5'h1F, 8'd35, 8'd5, 8'h04, 1'b0);
    run_check("hys37b",  all5(8'd37), 5'h1F, 8'd37, 8'd5, 8'h04, 1'b0);
    run_check("hys40",   all5(8'd40), 5'h1F, 8'd40, 8'd5, 8'h04, 1'b1);
    run_check("hys36",   all5(8'd36), 5'h1F, 8'd36, 8'd5, 8'h04, 1'b1);
    run_check("band19",  all5(8'd19), 5'h1F, 8'd19, 8'd5, 8'h02, 1'b0);
    run_check("band18",  all5(8'd18), 5'h1F, 8'd18, 8'd5, 8'h01, 1'b0);
    run_check("band26",  all5(8'd26), 5'h1F, 8'd26, 8'd5, 8'h02, 1'b0);
    run_check("band27",  all5(8'd27), 5'h1F, 8'd27, 8'd5, 8'h04, 1'b0);
    // 61/3 = 20 r1, 2*1 < 3 -> rounds down
    run_check("rnddown", pack5(20, 20, 21, 90, 90), 5'h07, 8'd20, 8'd3, 8'h02, 1'b0);
    run_check("max",     all5(8'd255), 5'h1F, 8'd255, 8'd5, 8'h04, 1'b1);

    // Reset during DIVIDE (edges 6..21): edge 10 is mid-division.
    @(negedge clk_i);
    start_i        = 1'b1;
    sensors_data_i = pack5(20, 21, 22, 23, 24);
    sensors_en_i   = 5'h1F;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    check_eq("abort.busy",  32'(busy_o), 32'd0);
    check_eq("abort.done",  32'(done_o), 32'd0);
    check_eq("abort.avg",   32'(avg_o), 32'd0);
    check_eq("abort.cnt",   32'(nr_active_o), 32'd0);
    check_eq("abort.led",   32'(led_output_o), 32'd0);
    check_eq("abort.alert", 32'(alert_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(posedge clk_i);
      #1;
      if (done_o) ndone++;
    end
    check_eq("abort.no_done", 32'(ndone), 32'd0);
    run_check("after_rst", pack5(20, 21, 22, 23, 24), 5'h1F, 8'd22, 8'd5, 8'h02, 1'b0);

    // start held high: data change mid-ACCUM ignored; second run begins
    // from IDLE at edge 24 with the new data, done at edge 46.
    @(negedge clk_i);
    start_i        = 1'b1;
    sensors_data_i = pack5(20, 21, 22, 23, 24);
    sensors_en_i   = 5'h1F;
    @(posedge clk_i);
    ndone    = 0;
    first_e  = 0;
    second_e = 0;
    for (int e = 1; e <= 50; e++) begin
      @(posedge clk_i);
      #1;
      if (e == 2)  sensors_data_i = all5(8'd99);
      if (e == 24) start_i = 1'b0;
      if (done_o) begin
        ndone++;
        if (ndone == 1) begin
          first_e = e;
          check_eq("held.avg1", 32'(avg_o), 32'd22);
          check_eq("held.cnt1", 32'(nr_active_o), 32'd5);
          check_eq("held.alert1", 32'(alert_o), 32'd0);
        end else if (ndone == 2) begin
          second_e = e;
          check_eq("held.avg2", 32'(avg_o), 32'd99);
          check_eq("held.led2", 32'(led_output_o), 32'h04);
          check_eq("held.alert2", 32'(alert_o), 32'd1);
        end
      end
    end
    check_eq("held.ndone", 32'(ndone), 32'd2);
    check_eq("held.edge1", 32'(first_e), 32'd22);
    check_eq("held.edge2", 32'(second_e), 32'd46);
    check_eq("held.idle_busy", 32'(busy_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/temperature_monitor.md
TEMPERATURE_MONITOR -- requirements
Module: temperature_monitor

Interface
REQ-001 The block SHALL have parameter NR_SENSORS, default 5, meaning the number of sensor channels (1..32).
REQ-002 The block SHALL have parameter ALERT_HI, default 40, meaning the average (°C) at or above which the alert sets.
REQ-003 The block SHALL have parameter ALERT_LO, default 35, meaning the average (°C) at or below which the alert clears.
REQ-004 clk_i  input  1  is the single clock; all logic is rising-edge.
REQ-005 rst_n_i  input  1  is the reset, asynchronous and active-low.
REQ-006 start_i  input  1  is the measurement request; it is sampled only in IDLE.
REQ-007 sensors_data_i  input  8*NR_SENSORS  holds the unsigned 8-bit temperatures, with sensor k at bits [8k+7:8k].
REQ-008 sensors_en_i  input  NR_SENSORS  holds the per-sensor enable bits.
REQ-009 busy_o  output  1  SHALL be high from the start edge until DONE is entered.
REQ-010 done_o  output  1  SHALL be a one-cycle pulse marking a valid result.
REQ-011 avg_o  output  8  SHALL hold the rounded average of the enabled sensors.
REQ-012 nr_active_o  output  8  SHALL hold the count of enabled sensors.
REQ-013 led_output_o  output  8  SHALL hold the display code.
REQ-014 alert_o  output  1  SHALL be the alarm flag, with hysteresis.

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM, DIVIDE, ROUND and DONE; DONE SHALL return to IDLE after 1 cycle.
REQ-016 When start_i=1 in IDLE, the block SHALL latch sensors_data_i and sensors_en_i into registers, clear the sum and count, and go to ACCUM; later input changes SHALL be ignored.
REQ-017 ACCUM SHALL process one sensor per cycle (index 0..NR_SENSORS-1); enabled sensors add to a 16-bit sum and increment an 8-bit count; after NR_SENSORS cycles the FSM goes to DIVIDE.
REQ-018 DIVIDE SHALL run a 16-bit restoring division (sum / {8'b0,count}) at one quotient bit per cycle, taking exactly 16 cycles, then go to ROUND.
REQ-019 ROUND SHALL compute avg = Q+1 if 2*R >= count, otherwise Q, saturated to 255; if count==0, avg SHALL be forced to 0 and the division result discarded.
REQ-020 Latency SHALL be fixed: with the start edge as edge 0, results and done_o=1 SHALL become visible after edge NR_SENSORS+17; for N=5 this is edge 22.
REQ-021 avg_o, nr_active_o, led_output_o and alert_o SHALL update only on entry to DONE and SHALL hold between measurements.
REQ-022 led_output_o SHALL be 8'h00 when count==0, 8'h01 when avg<19, 8'h02 when avg is 19..26, and 8'h04 when avg>26.
REQ-023 alert_o SHALL set on DONE when count==0 or avg>=ALERT_HI.
REQ-024 alert_o SHALL clear on DONE when count>0 and avg<=ALERT_LO.
REQ-025 alert_o SHALL otherwise hold its previous value.
REQ-026 start_i asserted in any state other than IDLE SHALL be ignored and not queued; start_i high on the DONE→IDLE cycle takes effect in the next IDLE cycle.

Reset
REQ-027 While rst_n_i=0, the FSM SHALL be in IDLE, and busy_o, done_o, avg_o, nr_active_o, led_output_o, alert_o and all internal registers SHALL be 0.
REQ-028 Reset asserted mid-operation (any state) SHALL abort the measurement with no done_o pulse; the first start_i after release SHALL run a full measurement.

Structure
REQ-029 Package temperature_pkg SHALL hold the FSM state encoding, the LED code constants (LED_NONE, LED_COLD, LED_OK, LED_HOT) and the band limits 19/26.
REQ-030 The division SHALL be a sub-module seq_divider (16-bit, start/done, one bit per cycle, registered Q/R), instantiated once.

Verification
REQ-031 Sensors 20,21,22,23,24, all enabled, start -> done_o at edge 22, avg_o=22, nr_active_o=5, led_output_o=8'h02, alert_o=0.
REQ-032 Sensors 10,11 enabled, others disabled -> 21/2 gives Q=10, R=1; 2*R>=2 so avg_o=11, led_output_o=8'h01.
REQ-033 sensors_en_i=0 -> avg_o=0, nr_active_o=0, led_output_o=8'h00, alert_o=1.
REQ-034 Hysteresis sequence of all-sensor averages 42, 37, 35, 37 -> alert_o = 1, 1, 0, 0; led_output_o=8'h04 on each.
REQ-035 rst_n_i pulsed low during DIVIDE -> all outputs 0 immediately with no done_o; a new start gives the correct result at edge 22.
REQ-036 start_i held high for a whole run, with data changed mid-ACCUM -> exactly one result per run, computed from the latched data, and a back-to-back run starts from IDLE.
